// File: rtl/mem_stage_mmio_if.sv
// MEM-stage request/response bundle between the EX/MEM pipeline side (master)
// and the memory-mapped MEM stage (slave).
interface mem_stage_mmio_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
);
  logic              mem_req_m;
  logic              mem_write_m;
  logic [ADDR_W-1:0] alu_result_memory_in;
  logic [DATA_W-1:0] write_data_memory_in;
  logic [DATA_W-1:0] read_data_memory;
  logic              stall_m;
  logic              fault_m;
  logic              fault_sticky;
  logic [ADDR_W-1:0] fault_addr;

  modport master (
    output mem_req_m, mem_write_m, alu_result_memory_in, write_data_memory_in,
    input  read_data_memory, stall_m, fault_m, fault_sticky, fault_addr
  );

  modport slave (
    input  mem_req_m, mem_write_m, alu_result_memory_in, write_data_memory_in,
    output read_data_memory, stall_m, fault_m, fault_sticky, fault_addr
  );
endinterface

// File: rtl/mem_stage_mmio.sv
// MEM pipeline stage: zero-wait data RAM plus a multi-cycle narrow image RAM
// that stalls the pipeline, with unmapped-access fault capture.
module mem_stage_mmio #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 24,
  parameter int DATA_DEPTH = 1024,
  parameter int IMG_BASE   = 'h10000,
  parameter int IMG_DEPTH  = 65536,
  parameter int IMG_W      = 8,
  parameter int IMG_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_stage_mmio_if.slave  bus
);

  localparam int DA_W  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int IX_W  = (IMG_DEPTH > 1) ? $clog2(IMG_DEPTH) : 1;
  localparam int CNT_W = (IMG_LAT > 1) ? $clog2(IMG_LAT) : 1;

  localparam logic [ADDR_W:0]  DATA_END_C = (ADDR_W+1)'(DATA_DEPTH);
  localparam logic [ADDR_W:0]  IMG_LO_C   = (ADDR_W+1)'(IMG_BASE);
  localparam logic [ADDR_W:0]  IMG_HI_C   = (ADDR_W+1)'(IMG_BASE + IMG_DEPTH);
  localparam logic [ADDR_W-1:0] IMG_BASE_C = ADDR_W'(IMG_BASE);
  localparam logic [CNT_W-1:0] CNT_LOAD_C = CNT_W'(IMG_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic             LAT_ONE_C  = (IMG_LAT == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rd_q;
  logic              fault_sticky_q;
  logic [ADDR_W-1:0] fault_addr_q;

  logic [DATA_W-1:0] dram_q [DATA_DEPTH];
  logic [IMG_W-1:0]  iram_q [IMG_DEPTH];

  logic [ADDR_W:0]   addr_ext_s;
  logic              hit_d_s;
  logic              hit_i_s;
  logic              fault_s;
  logic [DA_W-1:0]   dram_idx_s;
  logic [IX_W-1:0]   img_idx_s;
  logic              img_last_s;
  logic              img_commit_s;
  logic              dram_we_s;
  logic              iram_we_s;
  logic              stall_s;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rdata_s;

  // Address decode and write-enable generation
  always_comb begin
    addr_ext_s = {1'b0, bus.alu_result_memory_in};
    hit_d_s    = (addr_ext_s < DATA_END_C);
    hit_i_s    = (addr_ext_s >= IMG_LO_C) && (addr_ext_s < IMG_HI_C);
    fault_s    = bus.mem_req_m && !hit_d_s && !hit_i_s;
    dram_idx_s = DA_W'(bus.alu_result_memory_in);
    img_idx_s  = IX_W'(bus.alu_result_memory_in - IMG_BASE_C);
    // Last stall cycle: the image access completes at the end of this cycle.
    if (state_q == ST_BUSY) begin
      img_last_s = (cnt_q == CNT_ONE_C);
    end else if (state_q == ST_IDLE) begin
      img_last_s = LAT_ONE_C;
    end else begin
      img_last_s = 1'b0;
    end
    img_commit_s = bus.mem_req_m && hit_i_s && img_last_s && !rst;
    dram_we_s    = bus.mem_req_m && bus.mem_write_m && hit_d_s &&
                   (state_q == ST_IDLE) && !rst;
    iram_we_s    = img_commit_s && bus.mem_write_m;
  end

  // Image load value, truncated width zero-extended onto the data bus
  always_comb begin
    rd_d = '0;
    if (bus.mem_write_m) begin
      rd_d = '0;
    end else begin
      rd_d = DATA_W'(iram_q[img_idx_s]);
    end
  end

  // Stall and read-data selection
  always_comb begin
    stall_s = 1'b0;
    rdata_s = '0;
    if (rst) begin
      stall_s = 1'b0;
      rdata_s = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          stall_s = bus.mem_req_m && hit_i_s;
          if (bus.mem_req_m && !bus.mem_write_m && hit_d_s) begin
            rdata_s = dram_q[dram_idx_s];
          end else begin
            rdata_s = '0;
          end
        end
        ST_BUSY: begin
          stall_s = 1'b1;
          rdata_s = '0;
        end
        ST_DONE: begin
          stall_s = 1'b0;
          rdata_s = rd_q;
        end
        default: begin
          stall_s = 1'b0;
          rdata_s = '0;
        end
      endcase
    end
  end

  // Image-access FSM, latency counter and first-fault capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      rd_q           <= '0;
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      if (fault_s && !fault_sticky_q) begin
        fault_sticky_q <= 1'b1;
        fault_addr_q   <= bus.alu_result_memory_in;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req_m && hit_i_s) begin
            if (LAT_ONE_C) begin
              state_q <= ST_DONE;
              rd_q    <= rd_d;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= CNT_LOAD_C;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_ONE_C) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            rd_q    <= rd_d;
          end else begin
            cnt_q <= cnt_q - CNT_ONE_C;
          end
        end
        // The request is still on the inputs here; it must not restart.
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // RAM arrays keep their contents across reset
  always_ff @(posedge clk) begin
    if (dram_we_s) begin
      dram_q[dram_idx_s] <= bus.write_data_memory_in;
    end
    if (iram_we_s) begin
      iram_q[img_idx_s] <= IMG_W'(bus.write_data_memory_in);
    end
  end

  assign bus.read_data_memory = rdata_s;
  assign bus.stall_m          = stall_s;
  assign bus.fault_m          = fault_s;
  assign bus.fault_sticky     = fault_sticky_q;
  assign bus.fault_addr       = fault_addr_q;

endmodule

// File: tb/tb_mem_stage_mmio.sv
// Self-checking bench for mem_stage_mmio: reference memory model and a queue of
// expected load results compared when the stage stops stalling.
module tb_mem_stage_mmio;

  localparam int DATA_W     = 24;
  localparam int ADDR_W     = 24;
  localparam int DATA_DEPTH = 1024;
  localparam int IMG_BASE   = 'h10000;
  localparam int IMG_DEPTH  = 65536;
  localparam int IMG_W      = 8;
  localparam int IMG_LAT    = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [DATA_W-1:0] dram_m [int];
  logic [IMG_W-1:0]  img_m  [int];
  logic              sticky_m;
  logic [ADDR_W-1:0] faddr_m;
  logic [DATA_W-1:0] exp_q [$];

  mem_stage_mmio_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_stage_mmio #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_DEPTH(DATA_DEPTH), .IMG_BASE(IMG_BASE),
    .IMG_DEPTH(IMG_DEPTH), .IMG_W(IMG_W), .IMG_LAT(IMG_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_img(input int a);
    return (a >= IMG_BASE) && (a < IMG_BASE + IMG_DEPTH);
  endfunction

  // One access: expected stall pattern, fault flag and (for loads) read data.
  task automatic do_access(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
    int a;
    int lat;
    logic unmapped;
    logic exp_st;
    logic [DATA_W-1:0] exp_rd;
    a = int'(addr);
    unmapped = !(a < DATA_DEPTH) && !is_img(a);
    lat = is_img(a) ? IMG_LAT : 0;
    if (!wr) begin
      if (a < DATA_DEPTH) exp_rd = dram_m[a];
      else if (is_img(a)) exp_rd = {16'h0000, img_m[a - IMG_BASE]};
      else exp_rd = 24'h000000;
      exp_q.push_back(exp_rd);
    end
    bus.mem_req_m = 1'b1;
    bus.mem_write_m = wr;
    bus.alu_result_memory_in = addr;
    bus.write_data_memory_in = wd;
    @(negedge clk);
    checks++;
    if (bus.fault_m !== unmapped)
      $display("FAIL fault_m addr=%h got=%b exp=%b", addr, bus.fault_m, unmapped);
    if (bus.fault_m !== unmapped) errors++;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      exp_st = (c < lat);
      checks++;
      if (bus.stall_m !== exp_st) begin
        errors++;
        $display("FAIL stall_m addr=%h cyc=%0d got=%b exp=%b", addr, c, bus.stall_m, exp_st);
      end
      if (c == lat && !wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty addr=%h got=%h exp=<none>", addr, bus.read_data_memory);
        end else begin
          exp_rd = exp_q.pop_front();
          if (bus.read_data_memory !== exp_rd) begin
            errors++;
            $display("FAIL read_data addr=%h got=%h exp=%h", addr, bus.read_data_memory, exp_rd);
          end
        end
      end
    end
    @(posedge clk); #1;
    if (wr && a < DATA_DEPTH) dram_m[a] = wd;
    if (wr && is_img(a)) img_m[a - IMG_BASE] = wd[IMG_W-1:0];
    if (unmapped && !sticky_m) begin
      sticky_m = 1'b1;
      faddr_m = addr;
    end
  endtask

  // Idle cycle: no request, outputs quiet, fault capture matches the model.
  task automatic idle_check(input string tag);
    bus.mem_req_m = 1'b0;
    bus.mem_write_m = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall_m !== 1'b0 || bus.read_data_memory !== 24'h000000) begin
      errors++;
      $display("FAIL %s_idle stall=%b read=%h exp stall=0 read=000000", tag, bus.stall_m, bus.read_data_memory);
    end
    checks++;
    if (bus.fault_sticky !== sticky_m || bus.fault_addr !== faddr_m) begin
      errors++;
      $display("FAIL %s_fault_capture got=%b/%h exp=%b/%h", tag, bus.fault_sticky, bus.fault_addr, sticky_m, faddr_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mem_req_m = 1'b1;
    bus.mem_write_m = 1'b0;
    bus.alu_result_memory_in = 24'h000000;
    bus.write_data_memory_in = 24'h000000;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.read_data_memory !== 24'h000000 || bus.stall_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs read=%h stall=%b exp read=000000 stall=0", bus.read_data_memory, bus.stall_m);
    end
    checks++;
    if (bus.fault_sticky !== 1'b0 || bus.fault_addr !== 24'h000000) begin
      errors++;
      $display("FAIL reset_fault got=%b/%h exp=0/000000", bus.fault_sticky, bus.fault_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sticky_m = 1'b0;
    faddr_m = 24'h000000;
    idle_check("reset");
  endtask

  task automatic test_data();
    do_access(1'b1, 24'd5, 24'hABCDEF);
    do_access(1'b0, 24'd5, 24'h000000);
  endtask

  task automatic test_image();
    do_access(1'b1, 24'(IMG_BASE + 3), 24'h0000A5);
    do_access(1'b0, 24'(IMG_BASE + 3), 24'h000000);
    idle_check("image");
  endtask

  task automatic test_fault();
    do_access(1'b1, 24'(IMG_BASE), 24'h000077);
    do_access(1'b0, 24'hFFFFF0, 24'h000000);
    do_access(1'b1, 24'(IMG_BASE + IMG_DEPTH), 24'h123456);
    idle_check("fault");
    do_access(1'b0, 24'(IMG_BASE), 24'h000000);
    do_access(1'b0, 24'd5, 24'h000000);
  endtask

  task automatic test_reset_busy();
    do_access(1'b1, 24'(IMG_BASE + 7), 24'h000055);
    bus.mem_req_m = 1'b1;
    bus.mem_write_m = 1'b1;
    bus.alu_result_memory_in = 24'(IMG_BASE + 7);
    bus.write_data_memory_in = 24'h000012;
    @(negedge clk);
    checks++;
    if (bus.stall_m !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_start got=%b exp=1", bus.stall_m);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sticky_m = 1'b0;
    faddr_m = 24'h000000;
    idle_check("rst_busy");
    do_access(1'b0, 24'(IMG_BASE + 7), 24'h000000);
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 24'(IMG_BASE + 3), 24'h000000);
    do_access(1'b0, 24'd5, 24'h000000);
    idle_check("b2b");
  endtask

  task automatic test_boundaries();
    do_access(1'b1, 24'(DATA_DEPTH - 1), 24'h135790);
    do_access(1'b0, 24'(DATA_DEPTH - 1), 24'h000000);
    do_access(1'b1, 24'(IMG_BASE + IMG_DEPTH - 1), 24'hFFFF3C);
    do_access(1'b0, 24'(IMG_BASE + IMG_DEPTH - 1), 24'h000000);
    do_access(1'b0, 24'(IMG_BASE), 24'h000000);
    do_access(1'b0, 24'(IMG_BASE + IMG_DEPTH), 24'h000000);
    idle_check("boundary");
    do_access(1'b0, 24'd6000, 24'h000000);
    idle_check("second_fault");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    sticky_m = 1'b0;
    faddr_m = 24'h000000;
    test_reset();
    test_data();
    test_image();
    test_fault();
    test_reset_busy();
    test_back_to_back();
    test_boundaries();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
